// File: rtl/mat_mult_host.sv
// Host front end for the NxN matrix multiplier: register-mapped A/B operand
// files, a run sequencer (IDLE -> RUN -> CAPTURE) and a captured result file.
// Ports: clk/rst (async, active high); host side wr_en, rd_en, addr, wdata,
// rdata/rd_valid (1-cycle registered read), irq (= done); multiplier side
// mm_en, mm_mat_mode, mm_dataa, mm_datab (flat [row][col][bit]), mm_result.
module mat_mult_host #(
   parameter int N              = 6,
   parameter int W              = 36,
   parameter int RUN_CYCLES_MAT = 11,
   parameter int RUN_CYCLES_PAR = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [7:0]         addr,
   input  logic [W-1:0]       wdata,
   output logic [W-1:0]       rdata,
   output logic               rd_valid,
   output logic               irq,
   output logic               mm_en,
   output logic               mm_mat_mode,
   output logic [N*N*W-1:0]   mm_dataa,
   output logic [N*N*W-1:0]   mm_datab,
   input  logic [N*N*W-1:0]   mm_result
);

   localparam int NE = N * N;
   localparam int CW = 8;

   typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [W-1:0]    a_reg   [NE];
   logic [W-1:0]    b_reg   [NE];
   logic [W-1:0]    res_reg [NE];
   logic            done;
   logic            mode_latched;

   // Address decode: addr[7:6] selects the region, addr[5:0] the element.
   logic [1:0]      region;
   logic [5:0]      idx;
   logic            idx_ok;
   logic            busy;
   logic            wr_ctrl;
   logic            start_go;
   logic [W-1:0]    rd_mux;

   assign region   = addr[7:6];
   assign idx      = addr[5:0];
   assign idx_ok   = (idx < 6'(NE));
   assign busy     = (state != IDLE);
   assign wr_ctrl  = wr_en && (addr == 8'hC0);
   assign start_go = wr_ctrl && wdata[0] && !busy;
   assign irq      = done;

   for (genvar g = 0; g < NE; g++) begin : g_ops
      assign mm_dataa[g*W +: W] = a_reg[g];
      assign mm_datab[g*W +: W] = b_reg[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Run counter counts RUN cycles down to 1, so mm_en is high for exactly
   // the loaded number of cycles.  In CAPTURE the mode stays latched so the
   // multiplier holds its result while it is copied.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      mm_en       = 1'b0;
      mm_mat_mode = 1'b0;
      case (state)
         IDLE: begin
            if (start_go) begin
               state_nxt = RUN;
               cnt_nxt   = wdata[1] ? CW'(RUN_CYCLES_MAT) : CW'(RUN_CYCLES_PAR);
            end
         end
         RUN: begin
            mm_en       = 1'b1;
            mm_mat_mode = mode_latched;
            cnt_nxt     = cnt - 1'b1;
            if (cnt == CW'(1)) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            mm_mat_mode = mode_latched;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NE; i++) begin
            a_reg[i]   <= '0;
            b_reg[i]   <= '0;
            res_reg[i] <= '0;
         end
         done         <= 1'b0;
         mode_latched <= 1'b0;
      end else begin
         // Operand files are frozen while a run is in flight.
         if (wr_en && !busy && idx_ok && region == 2'd0) a_reg[idx] <= wdata;
         if (wr_en && !busy && idx_ok && region == 2'd1) b_reg[idx] <= wdata;
         if (state == CAPTURE) begin
            for (int i = 0; i < NE; i++) res_reg[i] <= mm_result[i*W +: W];
         end
         if (start_go) mode_latched <= wdata[1];
         // start clears done (covers start+clear_done in one word); a capture
         // completing in the same cycle as a clear_done leaves done set.
         if (start_go)                done <= 1'b0;
         else if (state == CAPTURE)   done <= 1'b1;
         else if (wr_ctrl && wdata[2]) done <= 1'b0;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (region)
         2'd0: if (idx_ok) rd_mux = a_reg[idx];
         2'd1: if (idx_ok) rd_mux = b_reg[idx];
         2'd2: if (idx_ok) rd_mux = res_reg[idx];
         default: if (idx == 6'd0) rd_mux = W'({mode_latched, done, busy});
      endcase
   end

   // Read samples pre-write register contents, so a same-address write
   // in the same cycle is not visible until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_mat_mult_host.sv
module tb_mat_mult_host;
   localparam int N    = 6;
   localparam int W    = 36;
   localparam int NE   = N * N;
   localparam int FRAC = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic [7:0]       addr = '0;
   logic [W-1:0]     wdata = '0;
   logic [W-1:0]     rdata;
   logic             rd_valid;
   logic             irq;
   logic             mm_en;
   logic             mm_mat_mode;
   logic [NE*W-1:0]  mm_dataa;
   logic [NE*W-1:0]  mm_datab;
   logic [NE*W-1:0]  mm_result;

   mat_mult_host #(.N(N), .W(W), .RUN_CYCLES_MAT(11), .RUN_CYCLES_PAR(6)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .irq(irq),
      .mm_en(mm_en), .mm_mat_mode(mm_mat_mode), .mm_dataa(mm_dataa),
      .mm_datab(mm_datab), .mm_result(mm_result)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int en_cnt   = 0;   // cycles with mm_en high
   int mat_cnt  = 0;   // cycles with mm_en and mm_mat_mode both high
   int k        = 0;   // multiplier-model internal counter

   // Multiplier model: counter advances while enabled and is forced to 0
   // when en=0 and mat_mode=0.  Output is valid only after enough enabled
   // cycles; before that it shows a recognisable garbage pattern.
   always @(posedge clk) begin
      if (mm_en) begin
         en_cnt <= en_cnt + 1;
         k      <= k + 1;
         if (mm_mat_mode) mat_cnt <= mat_cnt + 1;
      end else if (!mm_mat_mode) begin
         k <= 0;
      end
   end

   function automatic logic [NE*W-1:0] mm_model(input logic [NE*W-1:0] a,
                                                input logic [NE*W-1:0] b,
                                                input logic mat, input int kk);
      logic [NE*W-1:0]   r;
      logic signed [79:0] acc, av, bv;
      r = '0;
      for (int e = 0; e < NE; e++) begin
         if (mat && kk >= 2*N-1) begin
            acc = '0;
            for (int j = 0; j < N; j++) begin
               av  = $signed(a[((e/N)*N+j)*W +: W]);
               bv  = $signed(b[(j*N+(e%N))*W +: W]);
               acc = acc + av * bv;
            end
            acc = acc >>> FRAC;
            r[e*W +: W] = acc[W-1:0];
         end else if (!mat && kk >= 6) begin
            r[e*W +: W] = W'(36'h100 + e);
         end else begin
            r[e*W +: W] = W'(36'hBAD000000 | e);
         end
      end
      return r;
   endfunction

   always_comb mm_result = mm_model(mm_dataa, mm_datab, mm_mat_mode, k);

   logic [W-1:0] b_sh [NE];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] ad, input logic [W-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; addr = ad; wdata = d;
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] ad, output logic [W-1:0] d);
      @(negedge clk);
      rd_en = 1'b1; addr = ad;
      @(posedge clk);
      #1 rd_en = 1'b0;
      chk("rd_valid_pulse", rd_valid, 1'b1);
      d = rdata;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] ad, input logic [W-1:0] exp);
      logic [W-1:0] d;
      rd(ad, d);
      chk(tag, d, exp);
   endtask

   // Counts negedge samples with irq low until irq rises (bounded).
   task automatic wait_done(output int busy_cyc);
      busy_cyc = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (irq) break;
         busy_cyc++;
      end
      chk("irq_rise", irq, 1'b1);
   endtask

   task automatic run(input logic mode, input int exp_en);
      int e0, m0, bc;
      e0 = en_cnt; m0 = mat_cnt;
      wr(8'hC0, W'({mode, 1'b1}));
      wait_done(bc);
      chk("busy_cycles", bc, exp_en + 1);
      chk("en_cycles", en_cnt - e0, exp_en);
      chk("mat_mode_cycles", mat_cnt - m0, mode ? exp_en : 0);
   endtask

   task automatic load_identity_random_b();
      for (int e = 0; e < NE; e++) begin
         if (e / N == e % N) wr(8'(e), W'(1) << FRAC);
         else                wr(8'(e), '0);
         b_sh[e] = W'({$urandom(), $urandom()});
         wr(8'(8'h40 + e), b_sh[e]);
      end
   endtask

   task automatic check_results_b();
      for (int e = 0; e < NE; e++) rd_chk("res_eq_b", 8'(8'h80 + e), b_sh[e]);
   endtask

   initial begin
      logic [W-1:0] d;
      int e0, bc;

      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Reset mid-simulation after some state has been loaded.
      wr(8'h00, 36'hABC);
      wr(8'h45, 36'h777);
      wr(8'hC0, 36'h1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mm_en", mm_en, 1'b0);
      chk("rst_mm_mat_mode", mm_mat_mode, 1'b0);
      chk("rst_dataa_zero", |mm_dataa, 1'b0);
      chk("rst_datab_zero", |mm_datab, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_irq", irq, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      chk("rst_en_stays_low", en_cnt, 2);
      rd_chk("rst_ctrl", 8'hC0, '0);
      @(posedge clk); #1 chk("rd_valid_one_cycle", rd_valid, 1'b0);
      rd_chk("rst_res", 8'h85, '0);
      rd_chk("rst_a0", 8'h00, '0);
      rd_chk("unmapped_c5", 8'hC5, '0);
      rd_chk("unmapped_res36", 8'hA4, '0);

      // Load and readback.
      wr(8'h0F, 36'h123456789);
      chk("dataa_2_3", mm_dataa[15*W +: W], 36'h123456789);
      wr(8'h63, 36'hFFFFFFFFF);
      chk("datab_5_5", mm_datab[35*W +: W], 36'hFFFFFFFFF);
      rd_chk("rd_a_2_3", 8'h0F, 36'h123456789);
      rd_chk("rd_b_5_5", 8'h63, 36'hFFFFFFFFF);
      wr(8'h2A, 36'h1);
      rd_chk("unmapped_wr_ignored", 8'h2A, '0);

      // Simultaneous write and read of the same address.
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b1; addr = 8'h0F; wdata = 36'h5A5A;
      @(posedge clk);
      #1 wr_en = 1'b0; rd_en = 1'b0;
      chk("rw_same_old", rdata, 36'h123456789);
      rd_chk("rw_same_new", 8'h0F, 36'h5A5A);

      // Matrix run: identity A times random B.
      load_identity_random_b();
      run(1'b1, 11);
      check_results_b();
      rd_chk("ctrl_after_mat", 8'hC0, 36'h6);

      // Parallel run with the stub pattern.
      run(1'b0, 6);
      rd_chk("par_87", 8'h87, 36'h107);
      rd_chk("par_80", 8'h80, 36'h100);
      rd_chk("par_a3", 8'hA3, 36'h123);
      rd_chk("ctrl_after_par", 8'hC0, 36'h2);

      // Busy protection.
      e0 = en_cnt;
      wr(8'hC0, 36'h1);
      chk("start_clears_done", irq, 1'b0);
      wr(8'h00, 36'h5);
      wr(8'hC0, 36'h1);
      rd_chk("ctrl_busy", 8'hC0, 36'h1);
      wait_done(bc);
      rd_chk("a0_protected", 8'h00, W'(1) << FRAC);
      repeat (20) @(posedge clk);
      chk("single_run", en_cnt - e0, 6);
      #1 chk("irq_held", irq, 1'b1);
      wr(8'hC0, 36'h5);
      chk("start_clear_done0", irq, 1'b0);
      wait_done(bc);
      chk("start_clear_busy", bc, 7);
      wr(8'hC0, 36'h4);
      chk("clear_done_irq", irq, 1'b0);

      // Abort with reset during the fourth RUN cycle.
      wr(8'hC0, 36'h3);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_mm_en", mm_en, 1'b0);
      chk("abort_irq", irq, 1'b0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      rd_chk("abort_ctrl", 8'hC0, '0);
      rd_chk("abort_res0", 8'h80, '0);
      rd_chk("abort_res25", 8'h99, '0);
      load_identity_random_b();
      run(1'b1, 11);
      check_results_b();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mat_mult_host.md
Name: mat_mult_host

Overview:
- Host-side front end that drives the 6x6 matrix-multiplier interface (clk, rst, en, mat_mode, dataa, datab, result).
- It accepts element-wise writes of operand matrices A and B from a simple register-mapped host port.
- It sequences one multiply run and snapshots the result array. The host then reads the result back element by element.
- It sits between the bus slave and the matrix multiplier. It is the initiator/reader end of the multiplier's datapath.

Parameters:
- N, 6, matrix dimension (rows = cols).
- W, 36, element width in bits (two's-complement fixed point).
- RUN_CYCLES_MAT, 11, cycles mm_en is held high in matrix mode. 2N-1 is correct for a multiplier-array latency of at most N-2.
- RUN_CYCLES_PAR, 6, cycles mm_en is held high in parallel mode before capture.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  host write strobe.
- rd_en  in  1  host read strobe.
- addr  in  8  host word address.
- wdata  in  W  host write data.
- rdata  out  W  host read data (registered).
- rd_valid  out  1  rdata valid; pulses one cycle after rd_en.
- irq  out  1  level, high while the done flag is set.
- mm_en  out  1  multiplier enable.
- mm_mat_mode  out  1  1 = matrix mode, 0 = parallel mode.
- mm_dataa  out  N*N*W  operand A array, [row][col][bit].
- mm_datab  out  N*N*W  operand B array.
- mm_result  in  N*N*W  multiplier result array.

Behaviour:
- Address map (r = row, c = col, index = r*N+c, 0..35):
  - 0x00+index: A[r][c], R/W.
  - 0x40+index: B[r][c], R/W.
  - 0x80+index: captured result, RO.
  - 0xC0 CTRL write: bit0 start, bit1 mode (1 = matrix), bit2 clear_done.
  - 0xC0 CTRL read: bit0 busy, bit1 done, bit2 mode_latched.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Reset (async): FSM goes to IDLE. A, B and result registers are cleared to 0. All outputs are 0: mm_en, mm_mat_mode, mm_dataa, mm_datab, rdata, rd_valid, irq. done=0, mode_latched=0.
- mm_dataa and mm_datab are driven directly from the A/B register files at all times.
- FSM states:
  - IDLE:
    - mm_en=0 and mm_mat_mode=0. This forces the multiplier's internal counter to 0.
    - A/B writes are accepted.
    - A CTRL write with start=1 latches mode, clears done, loads run counter = RUN_CYCLES_MAT or RUN_CYCLES_PAR, and goes to RUN.
  - RUN:
    - mm_en=1 and mm_mat_mode=mode_latched.
    - The counter decrements each cycle. When it reaches 1, the next state is CAPTURE.
    - Exactly RUN_CYCLES_* cycles have mm_en=1.
  - CAPTURE:
    - mm_en=0 and mm_mat_mode is held at mode_latched, so the multiplier's result holds.
    - All N*N mm_result elements are copied into the result registers in this single cycle. done is set.
    - Next state is IDLE.
- busy = (state != IDLE).
- While busy:
  - A/B writes are dropped (registers unchanged).
  - A start is ignored.
  - clear_done is honoured.
- clear_done and start written in the same word: start wins, and done ends at 0.
- done stays set until clear_done or the next start. irq = done.
- Reads:
  - rdata and rd_valid are registered, with one-cycle latency.
  - A result read during RUN or CAPTURE returns the previous snapshot; the register updates only at the CAPTURE edge.
  - Simultaneous wr_en and rd_en to the same address: the read returns the old value.
- Width rules: no arithmetic is done here. Data passes through at full W bits with no truncation or sign change.
- Reset mid-RUN: the run aborts immediately and the multiplier enable drops asynchronously. There is no done and no irq.

Test Plan:
- Reset state: assert rst mid-sim -> all outputs 0; CTRL read = 0; any result read = 0; rd_valid pulses exactly one cycle after rd_en.
- Load and readback: write A[2][3] (addr 0x0F) = 0x123456789 and B[5][5] (addr 0x63) = 0xFFFFFFFFF -> reads return the same values; mm_dataa[2][3] = 0x123456789 on the next cycle.
- Matrix run with real multiplier: A = identity in the fixed-point format, B[r][c] = r*N+c scaled, start with mode=1 -> mm_en high exactly 11 cycles, busy for 12 cycles, irq rises; result reads equal B element for element.
- Parallel run with stub multiplier: stub returns result[r][c] = 0x100+r*N+c; start with mode=0 -> mm_en high 6 cycles with mm_mat_mode=0; read 0x87 = 0x107.
- Busy protection: during RUN, write A[0][0]=5 and write start again -> A[0][0] unchanged; still exactly one run; clear_done during RUN leaves done=0 after CAPTURE is not required. Instead, write clear_done after irq -> irq falls the next cycle.
- Abort: assert rst at cycle 4 of RUN -> mm_en=0 immediately, done=0, result registers 0; a following start performs a clean full run.
